// File: rtl/datapath_arbiter_pkg.sv
// Shared types for the datapath arbiter slice: opcode, in-flight tag and FSM state encodings.
package datapath_pkg;

   localparam int OPCODE_W = 3;
   localparam int ID_W     = 3;

   typedef logic [OPCODE_W-1:0] opcode_t;

   typedef struct packed {
      logic            valid;
      logic [ID_W-1:0] id;
   } tag_t;

   typedef logic [1:0] state_t;

   localparam state_t ST_RUN   = 2'd0;
   localparam state_t ST_DRAIN = 2'd1;
   localparam state_t ST_HELD  = 2'd2;

endpackage

// File: rtl/datapath_arbiter_rr.sv
// Combinational round-robin picker: first eligible requester at or after ptr wins.
module rr_arbiter #(
   parameter int NREQ = 4,
   parameter int PW   = 2
) (
   input  logic [NREQ-1:0] eligible,
   input  logic [PW-1:0]   ptr,
   output logic [NREQ-1:0] grant,
   output logic [PW-1:0]   next_ptr
);

   localparam int unsigned NREQ_U = NREQ;

   logic        found;
   int unsigned idx;

   always_comb begin
      grant    = '0;
      next_ptr = ptr;
      found    = 1'b0;
      idx      = 0;
      for (int unsigned off = 0; off < NREQ_U; off++) begin
         idx = (32'(ptr) + off) % NREQ_U;
         if (!found && eligible[idx]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
            next_ptr   = PW'((idx + 1) % NREQ_U);
         end
      end
   end

endmodule

// File: rtl/datapath_arbiter.sv
// Round-robin sharing of one pipelined datapath among NREQ requesters, with hold/drain control.
// Optional performance counters are built when DATAPATH_ARB_PERF_EN is defined.
module datapath_arbiter
   import datapath_pkg::*;
#(
   parameter int N    = 16,
   parameter int PIPE = 2,
   parameter int NREQ = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [NREQ*N-1:0]    req_a,
   input  logic [NREQ*N-1:0]    req_b,
   input  logic [NREQ*3-1:0]    req_op,
   output logic [N-1:0]         dp_a,
   output logic [N-1:0]         dp_b,
   output logic [2:0]           dp_op,
   input  logic [N-1:0]         dp_y,
   input  logic                 dp_co,
   output logic [NREQ-1:0]      rsp_valid,
   output logic [N-1:0]         rsp_y,
   output logic                 rsp_co,
   input  logic                 hold,
   output logic                 hold_ack
`ifdef DATAPATH_ARB_PERF_EN
   ,
   output logic [31:0]          perf_issue_cnt,
   output logic [31:0]          perf_busy_cnt
`endif
);

   localparam int PW    = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int DEPTH = PIPE + 1;
   localparam int unsigned NREQ_U  = NREQ;
   localparam int unsigned DEPTH_U = DEPTH;

   state_t            state_q, state_d;
   logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
   logic [NREQ-1:0]   out_q, out_d;
   logic [NREQ-1:0]   rsp_valid_q, rsp_valid_d;
   logic [N-1:0]      dp_a_q, dp_a_d, dp_b_q, dp_b_d;
   opcode_t           dp_op_q, dp_op_d;
   logic [N-1:0]      rsp_y_q, rsp_y_d;
   logic              rsp_co_q, rsp_co_d;
   tag_t              issue_tag_q, issue_tag_d;
   tag_t [DEPTH-1:0]  tag_q, tag_d;

   logic [NREQ-1:0]   eligible, grant;
   logic              grant_any, pipe_busy;
   logic [ID_W-1:0]   grant_id;
   logic [N-1:0]      sel_a, sel_b;
   opcode_t           sel_op;

   // Response for the tag at the end of the pipeline; its clear is visible to eligibility
   // in the same cycle so a requester can be re-granted on its response edge.
   always_comb begin
      rsp_valid_d = '0;
      for (int unsigned i = 0; i < NREQ_U; i++) begin
         rsp_valid_d[i] = tag_q[DEPTH-1].valid && (tag_q[DEPTH-1].id == ID_W'(i));
      end
      rsp_y_d  = tag_q[DEPTH-1].valid ? dp_y  : rsp_y_q;
      rsp_co_d = tag_q[DEPTH-1].valid ? dp_co : rsp_co_q;
   end

   always_comb begin
      eligible = '0;
      if (state_q == ST_RUN && !rst) begin
         eligible = req_valid & ~(out_q & ~rsp_valid_d);
      end
   end

   rr_arbiter #(
      .NREQ (NREQ),
      .PW   (PW)
   ) u_rr (
      .eligible (eligible),
      .ptr      (rr_ptr_q),
      .grant    (grant),
      .next_ptr (rr_ptr_d)
   );

   always_comb begin
      sel_a    = '0;
      sel_b    = '0;
      sel_op   = '0;
      grant_id = '0;
      for (int unsigned i = 0; i < NREQ_U; i++) begin
         if (grant[i]) begin
            sel_a    = req_a[i*N +: N];
            sel_b    = req_b[i*N +: N];
            sel_op   = req_op[i*3 +: 3];
            grant_id = ID_W'(i);
         end
      end
      grant_any = |grant;
   end

   // The issue tag travels with dp_*, then DEPTH stages align it with dp_y.
   always_comb begin
      out_d             = (out_q & ~rsp_valid_d) | grant;
      dp_a_d            = grant_any ? sel_a  : dp_a_q;
      dp_b_d            = grant_any ? sel_b  : dp_b_q;
      dp_op_d           = grant_any ? sel_op : dp_op_q;
      issue_tag_d.valid = grant_any;
      issue_tag_d.id    = grant_id;
      tag_d             = tag_q;
      tag_d[0]          = issue_tag_q;
      for (int unsigned i = 1; i < DEPTH_U; i++) begin
         tag_d[i] = tag_q[i-1];
      end
      pipe_busy = issue_tag_q.valid;
      for (int unsigned i = 0; i < DEPTH_U; i++) begin
         pipe_busy = pipe_busy | tag_q[i].valid;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RUN:   if (hold) state_d = ST_DRAIN;
         ST_DRAIN: begin
            if (!hold)          state_d = ST_RUN;
            else if (!pipe_busy) state_d = ST_HELD;
         end
         ST_HELD:  if (!hold) state_d = ST_RUN;
         default:  state_d = ST_RUN;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_RUN;
         rr_ptr_q    <= '0;
         out_q       <= '0;
         rsp_valid_q <= '0;
         rsp_y_q     <= '0;
         rsp_co_q    <= 1'b0;
         dp_a_q      <= '0;
         dp_b_q      <= '0;
         dp_op_q     <= '0;
         issue_tag_q <= '0;
         tag_q       <= '0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         out_q       <= out_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_y_q     <= rsp_y_d;
         rsp_co_q    <= rsp_co_d;
         dp_a_q      <= dp_a_d;
         dp_b_q      <= dp_b_d;
         dp_op_q     <= dp_op_d;
         issue_tag_q <= issue_tag_d;
         tag_q       <= tag_d;
      end
   end

   assign req_ready = grant;
   assign dp_a      = dp_a_q;
   assign dp_b      = dp_b_q;
   assign dp_op     = dp_op_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_y     = rsp_y_q;
   assign rsp_co    = rsp_co_q;
   assign hold_ack  = (state_q == ST_HELD);

`ifdef DATAPATH_ARB_PERF_EN
   logic [31:0] issue_cnt_q, issue_cnt_d, busy_cnt_q, busy_cnt_d;

   always_comb begin
      issue_cnt_d = issue_cnt_q + {31'd0, grant_any};
      busy_cnt_d  = busy_cnt_q + {31'd0, pipe_busy};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         issue_cnt_q <= '0;
         busy_cnt_q  <= '0;
      end else begin
         issue_cnt_q <= issue_cnt_d;
         busy_cnt_q  <= busy_cnt_d;
      end
   end

   assign perf_issue_cnt = issue_cnt_q;
   assign perf_busy_cnt  = busy_cnt_q;
`endif

endmodule

// File: tb/tb_datapath_arbiter.sv
// Directed bench for datapath_arbiter with an adder datapath stub of PIPE+1 register depth.
module tb_datapath_arbiter;

   localparam int N    = 16;
   localparam int PIPE = 2;
   localparam int NREQ = 4;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic [NREQ-1:0]   req_valid = '0;
   logic [NREQ-1:0]   req_ready;
   logic [NREQ*N-1:0] req_a = '0;
   logic [NREQ*N-1:0] req_b = '0;
   logic [NREQ*3-1:0] req_op = '0;
   logic [N-1:0]      dp_a, dp_b, dp_y;
   logic [2:0]        dp_op;
   logic              dp_co;
   logic [NREQ-1:0]   rsp_valid;
   logic [N-1:0]      rsp_y;
   logic              rsp_co;
   logic              hold = 1'b0;
   logic              hold_ack;
`ifdef DATAPATH_ARB_PERF_EN
   logic [31:0]       perf_issue_cnt, perf_busy_cnt;
`endif

   int vecs = 0;
   int errs = 0;

   datapath_arbiter #(.N(N), .PIPE(PIPE), .NREQ(NREQ)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_op    (req_op),
      .dp_a      (dp_a),
      .dp_b      (dp_b),
      .dp_op     (dp_op),
      .dp_y      (dp_y),
      .dp_co     (dp_co),
      .rsp_valid (rsp_valid),
      .rsp_y     (rsp_y),
      .rsp_co    (rsp_co),
      .hold      (hold),
      .hold_ack  (hold_ack)
`ifdef DATAPATH_ARB_PERF_EN
      ,
      .perf_issue_cnt (perf_issue_cnt),
      .perf_busy_cnt  (perf_busy_cnt)
`endif
   );

   always #5 clk = ~clk;

   // Adder stub: result of dp_* appears on dp_y PIPE+1 edges after dp_* is loaded.
   logic [N:0] stub_q [PIPE+1];
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i <= PIPE; i++) stub_q[i] <= '0;
      end else begin
         stub_q[0] <= {1'b0, dp_a} + {1'b0, dp_b};
         for (int i = 1; i <= PIPE; i++) stub_q[i] <= stub_q[i-1];
      end
   end
   assign dp_y  = stub_q[PIPE][N-1:0];
   assign dp_co = stub_q[PIPE][N];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic [N-1:0] a, input logic [N-1:0] b);
      req_a[i*N +: N] = a;
      req_b[i*N +: N] = b;
      req_op[i*3 +: 3] = 3'b000;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      req_valid = 4'b1111;
      tick();
      tick();
      vecs++; if (req_ready !== 4'b0000) begin errs++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
      vecs++; if (dp_a !== 16'd0 || dp_b !== 16'd0 || dp_op !== 3'd0) begin errs++; $display("FAIL reset_dp got=%h/%h/%h exp=0/0/0", dp_a, dp_b, dp_op); end
      vecs++; if (rsp_valid !== 4'b0000 || rsp_y !== 16'd0 || rsp_co !== 1'b0) begin errs++; $display("FAIL reset_rsp got=%b/%h/%b exp=0/0/0", rsp_valid, rsp_y, rsp_co); end
      vecs++; if (hold_ack !== 1'b0) begin errs++; $display("FAIL reset_hold_ack got=%b exp=0", hold_ack); end
`ifdef DATAPATH_ARB_PERF_EN
      vecs++; if (perf_issue_cnt !== 32'd0 || perf_busy_cnt !== 32'd0) begin errs++; $display("FAIL reset_perf got=%0d/%0d exp=0/0", perf_issue_cnt, perf_busy_cnt); end
`endif
      req_valid = '0;
      rst = 1'b0;
      tick();
   endtask

   task automatic test_single();
      set_req(0, 16'd100, -16'sd30);
      req_valid = 4'b0001;
      #1;
      vecs++; if (req_ready !== 4'b0001) begin errs++; $display("FAIL single_ready got=%b exp=0001", req_ready); end
      tick();
      vecs++; if (dp_a !== 16'd100 || dp_b !== 16'hFFE2 || dp_op !== 3'd0) begin errs++; $display("FAIL single_issue got=%h/%h/%h exp=0064/ffe2/0", dp_a, dp_b, dp_op); end
      for (int c = 1; c <= 3; c++) begin
         tick();
         vecs++; if (rsp_valid !== 4'b0000) begin errs++; $display("FAIL single_early_rsp c=%0d got=%b exp=0000", c, rsp_valid); end
         vecs++; if (req_ready !== ((c == 3) ? 4'b0001 : 4'b0000)) begin errs++; $display("FAIL single_ready_busy c=%0d got=%b", c, req_ready); end
      end
      vecs++; if (dp_a !== 16'd100) begin errs++; $display("FAIL single_dp_hold got=%h exp=0064", dp_a); end
      req_valid = '0;
      tick();
      vecs++; if (rsp_valid !== 4'b0001 || rsp_y !== 16'd70 || rsp_co !== 1'b1) begin errs++; $display("FAIL single_rsp got=%b/%0d/%b exp=0001/70/1", rsp_valid, rsp_y, rsp_co); end
      tick();
      vecs++; if (rsp_valid !== 4'b0000 || rsp_y !== 16'd70) begin errs++; $display("FAIL single_rsp_hold got=%b/%0d exp=0000/70", rsp_valid, rsp_y); end
      repeat (3) tick();
   endtask

   task automatic test_outstanding();
      logic [3:0] exp_r;
      set_req(2, 16'd7, 16'd5);
      req_valid = 4'b0100;
      #1;
      for (int e = 0; e < 10; e++) begin
         exp_r = (e % 4 == 0) ? 4'b0100 : 4'b0000;
         vecs++; if (req_ready !== exp_r) begin errs++; $display("FAIL outst_ready e=%0d got=%b exp=%b", e, req_ready, exp_r); end
         tick();
         exp_r = (e >= 4 && e % 4 == 0) ? 4'b0100 : 4'b0000;
         vecs++; if (rsp_valid !== exp_r) begin errs++; $display("FAIL outst_rsp e=%0d got=%b exp=%b", e, rsp_valid, exp_r); end
         if (e >= 4 && e % 4 == 0) begin
            vecs++; if (rsp_y !== 16'd12 || rsp_co !== 1'b0) begin errs++; $display("FAIL outst_y e=%0d got=%0d/%b exp=12/0", e, rsp_y, rsp_co); end
         end
      end
      req_valid = '0;
      repeat (6) tick();
   endtask

   task automatic test_boundary();
`ifdef DATAPATH_ARB_PERF_EN
      logic [31:0] cnt0;
      cnt0 = perf_issue_cnt;
`endif
      set_req(3, 16'hFFFF, 16'd1);
      req_valid = 4'b1000;
      #1;
      vecs++; if (req_ready !== 4'b1000) begin errs++; $display("FAIL bound_ready got=%b exp=1000", req_ready); end
      tick();
      req_valid = '0;
      vecs++; if (dp_a !== 16'hFFFF) begin errs++; $display("FAIL bound_issue got=%h exp=ffff", dp_a); end
`ifdef DATAPATH_ARB_PERF_EN
      vecs++; if (perf_issue_cnt !== cnt0 + 32'd1) begin errs++; $display("FAIL bound_perf got=%0d exp=%0d", perf_issue_cnt, cnt0 + 32'd1); end
`endif
      repeat (4) tick();
      vecs++; if (rsp_valid !== 4'b1000 || rsp_y !== 16'd0 || rsp_co !== 1'b1) begin errs++; $display("FAIL bound_rsp got=%b/%h/%b exp=1000/0000/1", rsp_valid, rsp_y, rsp_co); end
`ifdef DATAPATH_ARB_PERF_EN
      vecs++; if (perf_issue_cnt !== cnt0 + 32'd1) begin errs++; $display("FAIL bound_perf_idle got=%0d exp=%0d", perf_issue_cnt, cnt0 + 32'd1); end
`endif
      repeat (3) tick();
   endtask

   task automatic test_round_robin();
      logic [3:0]  exp_r;
      logic [15:0] exp_y;
      for (int i = 0; i < NREQ; i++) set_req(i, 16'(1000 * (i + 1)), 16'(i + 1));
      req_valid = 4'b1111;
      #1;
      for (int e = 0; e <= 8; e++) begin
         if (e <= 4) begin
            exp_r = 4'(4'b0001 << (e % 4));
            vecs++; if (req_ready !== exp_r) begin errs++; $display("FAIL rr_ready e=%0d got=%b exp=%b", e, req_ready, exp_r); end
         end
         tick();
         if (e == 4) req_valid = '0;
         if (e == 0) begin
            vecs++; if (dp_a !== 16'd1000) begin errs++; $display("FAIL rr_issue got=%0d exp=1000", dp_a); end
         end
         exp_r = (e >= 4) ? 4'(4'b0001 << ((e - 4) % 4)) : 4'b0000;
         vecs++; if (rsp_valid !== exp_r) begin errs++; $display("FAIL rr_rsp e=%0d got=%b exp=%b", e, rsp_valid, exp_r); end
         if (e >= 4) begin
            exp_y = 16'((((e - 4) % 4) + 1) * 1001);
            vecs++; if (rsp_y !== exp_y) begin errs++; $display("FAIL rr_y e=%0d got=%0d exp=%0d", e, rsp_y, exp_y); end
         end
      end
      repeat (3) tick();
   endtask

   task automatic test_hold();
      logic [3:0]  exp_r;
      logic [15:0] exp_y;
      req_valid = 4'b0111;
      #1;
      for (int e = 0; e <= 8; e++) begin
         case (e)
            0: exp_r = 4'b0010;
            1: exp_r = 4'b0100;
            2: exp_r = 4'b0001;
            default: exp_r = 4'b0000;
         endcase
         vecs++; if (req_ready !== exp_r) begin errs++; $display("FAIL hold_ready e=%0d got=%b exp=%b", e, req_ready, exp_r); end
         tick();
         if (e == 2) hold = 1'b1;
         case (e)
            4: begin exp_r = 4'b0010; exp_y = 16'd2002; end
            5: begin exp_r = 4'b0100; exp_y = 16'd3003; end
            6: begin exp_r = 4'b0001; exp_y = 16'd1001; end
            default: begin exp_r = 4'b0000; exp_y = rsp_y; end
         endcase
         vecs++; if (rsp_valid !== exp_r || rsp_y !== exp_y) begin errs++; $display("FAIL hold_rsp e=%0d got=%b/%0d exp=%b/%0d", e, rsp_valid, rsp_y, exp_r, exp_y); end
         if (e >= 3) begin
            vecs++; if (hold_ack !== (e >= 7)) begin errs++; $display("FAIL hold_ack e=%0d got=%b exp=%b", e, hold_ack, (e >= 7)); end
         end
      end
      hold = 1'b0;
      #1;
      vecs++; if (hold_ack !== 1'b1 || req_ready !== 4'b0000) begin errs++; $display("FAIL hold_release_pre got=%b/%b exp=1/0000", hold_ack, req_ready); end
      tick();
      vecs++; if (hold_ack !== 1'b0 || req_ready !== 4'b0010) begin errs++; $display("FAIL hold_resume got=%b/%b exp=0/0010", hold_ack, req_ready); end
      req_valid = '0;
      repeat (2) tick();
   endtask

   task automatic test_hold_idle();
      hold = 1'b1;
      tick();
      vecs++; if (hold_ack !== 1'b0) begin errs++; $display("FAIL idle_hold_e1 got=%b exp=0", hold_ack); end
      tick();
      vecs++; if (hold_ack !== 1'b1) begin errs++; $display("FAIL idle_hold_e2 got=%b exp=1", hold_ack); end
      hold = 1'b0;
      tick();
      vecs++; if (hold_ack !== 1'b0) begin errs++; $display("FAIL idle_release got=%b exp=0", hold_ack); end
   endtask

   task automatic test_reset_midflight();
      logic seen;
      seen = 1'b0;
      set_req(1, 16'd5, 16'd6);
      req_valid = 4'b0010;
      #1;
      vecs++; if (req_ready !== 4'b0010) begin errs++; $display("FAIL mid_ready got=%b exp=0010", req_ready); end
      tick();
      rst = 1'b1;
      #1;
      vecs++; if (dp_a !== 16'd0 || req_ready !== 4'b0000 || rsp_valid !== 4'b0000 || hold_ack !== 1'b0) begin errs++; $display("FAIL mid_reset_outputs got=%h/%b/%b/%b exp=0/0000/0000/0", dp_a, req_ready, rsp_valid, hold_ack); end
      tick();
      req_valid = '0;
      rst = 1'b0;
      for (int c = 0; c < 8; c++) begin
         tick();
         if (rsp_valid !== 4'b0000) seen = 1'b1;
      end
      vecs++; if (seen !== 1'b0) begin errs++; $display("FAIL mid_ghost_rsp got=%b exp=0", seen); end
   endtask

   initial begin
      #1;
      test_reset();
      test_single();
      test_outstanding();
      test_boundary();
      test_round_robin();
      test_hold();
      test_hold_idle();
      test_reset_midflight();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule

// File: doc/datapath_arbiter.md
Name: datapath_arbiter

Overview:
- Shares one pipelined arithmetic datapath (N-bit signed A/B, 3-bit opcode, Y/co outputs, PIPE register stages) between NREQ requesters.
- Round-robin arbitration with a valid/ready request handshake.
- Tracks in-flight operations with a tag pipeline aligned to the datapath latency, and routes each result back to its originator.
- Provides a hold/drain control so software or a top-level sequencer can quiesce the datapath.

Parameters:
- N, 16: operand/result width, matches datapath N.
- PIPE, 2: datapath latency in clock edges from operand capture to valid Y/co, matches datapath pipe.
- NREQ, 4: number of requesters, 2..8.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  request valid per requester.
- req_ready  out  NREQ  request accepted this cycle when req_valid[i] && req_ready[i].
- req_a  in  NREQ*N  packed operand A, requester i at bits [i*N +: N].
- req_b  in  NREQ*N  packed operand B.
- req_op  in  NREQ*3  packed opcode, requester i at [i*3 +: 3].
- dp_a  out  N  operand A to datapath (registered).
- dp_b  out  N  operand B to datapath (registered).
- dp_op  out  3  opcode to datapath (registered).
- dp_y  in  N  datapath result Y.
- dp_co  in  1  datapath carry-out.
- rsp_valid  out  NREQ  one-hot result strobe, single cycle.
- rsp_y  out  N  result, valid with any rsp_valid bit.
- rsp_co  out  1  carry, valid with any rsp_valid bit.
- hold  in  1  stop granting new requests.
- hold_ack  out  1  high while held and no operation in flight.

Behaviour:
- Reset (async, rst=1): dp_a/dp_b/dp_op=0, req_ready=0, rsp_valid=0, rsp_y=0, rsp_co=0, hold_ack=0, all tags invalid, rr pointer=0, FSM=RUN. An in-flight operation is discarded; its result is never reported.
- Arbitration:
  - At most one grant per cycle.
  - Round-robin starting at rr pointer. Eligible = req_valid[i] && !outstanding[i] && FSM==RUN.
  - req_ready[i] is combinational and one-hot (or zero); it is never high for a non-eligible requester.
  - After a grant to i, rr pointer = (i+1) mod NREQ. The pointer is unchanged when there is no grant.
- Issue: on the grant edge, dp_a/dp_b/dp_op capture the granted requester's operands. dp_* hold their value when there is no grant.
- Outstanding limit:
  - outstanding[i] is set on grant and cleared on its rsp_valid edge, so a requester has at most one op in flight.
  - If a grant and a response for the same i coincide, the response clear happens first, and the new grant sets the bit again.
- Tag pipeline: PIPE+1 stages of {valid, id}. The id enters at the grant edge, in the same cycle the operands enter dp_*.
- Response:
  - rsp_valid[id] is registered together with rsp_y<=dp_y and rsp_co<=dp_co when the tag reaches the last stage.
  - Latency from the accepting edge to the rsp_valid edge is PIPE+2 cycles (PIPE=2: request at edge k, rsp_valid high after edge k+4).
  - No response backpressure: requesters must sample rsp_* in the strobe cycle.
  - rsp_y/rsp_co hold their last value when rsp_valid=0.
- FSM states:
  - RUN: grants enabled. hold=1 -> DRAIN.
  - DRAIN: no grants. hold=0 -> RUN. Tag pipeline empty -> HELD.
  - HELD: hold_ack=1, no grants. hold=0 -> RUN, with hold_ack low the next cycle.
  - hold asserted with the pipeline already empty takes RUN -> DRAIN -> HELD (hold_ack 2 edges after hold).
  - In-flight results still return during DRAIN.
- Throughput: one op per cycle sustained across different requesters. With a single requester, issue is limited to once per PIPE+2 cycles by the outstanding rule.

Optional Feature:
- Macro DATAPATH_ARB_PERF_EN.
- When defined, adds port perf_issue_cnt (out, 32): counts grants, wraps at 2^32, reset to 0, frozen in HELD. It also adds port perf_busy_cnt (out, 32): counts cycles with any valid tag in flight.
- When undefined, neither port nor its counters exist. All other behaviour is identical.

Decomposition:
- Shared package datapath_pkg: OPCODE_W=3, typedef for opcode, typedef tag_t {valid, id}, FSM state enum {RUN, DRAIN, HELD}.
- One sub-module: rr_arbiter. Parameterised NREQ; takes eligible vector and pointer, returns one-hot grant and next pointer; purely combinational.
- The tag pipeline and FSM stay in datapath_arbiter.

Test Plan:
- Reset mid-flight: grant at cycle 3, assert rst at cycle 4 -> all outputs 0 immediately, no rsp_valid ever appears for that op.
- Single request, datapath stub computing A+B: req 0 with A=100, B=-30, op=000 -> rsp_valid=0001 after exactly PIPE+2 edges, rsp_y=70, req_ready[0]=0 until the response.
- All four requesters valid continuously -> grants 0,1,2,3 on consecutive cycles. Responses come back in the same order, one per cycle, and the next round resumes at 0 only after rsp for 0.
- Outstanding rule: requester 2 holds req_valid=1 for 10 cycles alone -> grants spaced PIPE+2 cycles apart, never two in flight.
- Hold with 3 ops in flight: assert hold -> no new req_ready, 3 responses still delivered, hold_ack rises the cycle after the last tag leaves. Deassert hold -> grants resume next cycle.
- Boundary: rr pointer at 3, only requester 3 valid -> grant 3, pointer wraps to 0. With DATAPATH_ARB_PERF_EN defined, perf_issue_cnt increments by exactly 1 per grant.
